// File: rtl/xge_pkt_gen_pkg.sv
// rtl/xge_pkt_gen_pkg.sv - Shared types and LFSR constants for the packet generator
package xge_pkt_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   typedef enum logic {
      PAT_INC  = 1'b0,
      PAT_LFSR = 1'b1
   } pat_mode_t;

   localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   // Right-shifting Galois step: the bit shifted out folds the taps back in
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/xge_lfsr32.sv
// rtl/xge_lfsr32.sv - 32-bit Galois LFSR with seed load and advance enable
module xge_lfsr32
   import xge_pkt_gen_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_en,
   input  logic        i_load,
   output logic [31:0] o_state
);

   logic [31:0] r_state;

   // Load reseeds; a load coinciding with a consumed beat lands one step past the seed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LFSR_SEED;
      end else if (i_load) begin
         r_state <= i_en ? lfsr_step(LFSR_SEED) : LFSR_SEED;
      end else if (i_en) begin
         r_state <= lfsr_step(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/xge_pkt_gen.sv
// rtl/xge_pkt_gen.sv - Burst frame generator driving the xge_mac pkt_tx interface
module xge_pkt_gen
   import xge_pkt_gen_pkg::*;
#(
   parameter int DATA_W  = 64,
   parameter int MOD_W   = $clog2(DATA_W/8),
   parameter int LEN_W   = 14,
   parameter int CNT_W   = 32,
   parameter int MIN_LEN = 64
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25,
   input  logic              cfg_start,
   input  logic              cfg_stop,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [CNT_W-1:0]  cfg_count,
   input  logic [7:0]        cfg_ipg,
   input  logic              cfg_mode,
   input  logic              pkt_tx_full,
   output logic [DATA_W-1:0] pkt_tx_data,
   output logic              pkt_tx_val,
   output logic              pkt_tx_sop,
   output logic              pkt_tx_eop,
   output logic [MOD_W-1:0]  pkt_tx_mod,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pkt_sent_cnt
);

   localparam int B = DATA_W / 8;
   localparam logic [LEN_W:0]   B_EXT   = (LEN_W+1)'(B);
   localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);

   // Latched run configuration
   state_t            r_state;
   logic [LEN_W-1:0]  r_len;
   logic [CNT_W-1:0]  r_count;
   logic [7:0]        r_ipg;
   pat_mode_t         r_mode;
   logic              r_stop;

   // Frame progress
   logic [LEN_W-1:0]  r_byte_cnt;
   logic              r_post_eop;
   logic [7:0]        r_gap;

   // Registered outputs
   logic [DATA_W-1:0] r_data;
   logic              r_val;
   logic              r_sop;
   logic              r_eop;
   logic [MOD_W-1:0]  r_mod;
   logic              r_busy;
   logic              r_done;
   logic [CNT_W-1:0]  r_sent;

   logic              w_idle;
   logic [LEN_W-1:0]  w_cfg_len_cl;
   logic [LEN_W-1:0]  w_len;
   pat_mode_t         w_mode;
   logic [LEN_W-1:0]  w_byte_cur;
   logic [CNT_W-1:0]  w_sent_base;
   logic [31:0]       w_lfsr_q;
   logic [31:0]       w_lfsr_cur;
   logic              w_last;
   logic              w_stop;
   logic              w_count_hit;
   logic              w_end;
   logic              w_issue;
   logic              w_load;
   logic [DATA_W-1:0] w_beat;

   // In IDLE the first beat is built straight from the cfg inputs so it can
   // leave on the same edge that accepts cfg_start
   assign w_idle       = (r_state == ST_IDLE);
   assign w_cfg_len_cl = (cfg_len < MIN_L) ? MIN_L : cfg_len;
   assign w_len        = w_idle ? w_cfg_len_cl : r_len;
   assign w_mode       = w_idle ? pat_mode_t'(cfg_mode) : r_mode;
   assign w_byte_cur   = w_idle ? '0 : r_byte_cnt;
   assign w_sent_base  = w_idle ? '0 : r_sent;
   assign w_lfsr_cur   = w_idle ? LFSR_SEED : w_lfsr_q;
   assign w_last       = (({1'b0, w_byte_cur} + B_EXT) >= {1'b0, w_len});

   assign w_stop       = r_stop | cfg_stop;
   assign w_count_hit  = (r_count != '0) && (r_sent == r_count);
   assign w_end        = r_post_eop && (w_count_hit || w_stop);
   assign w_load       = w_idle && cfg_start;

   // A beat leaves on this edge only if the MAC FIFO is not full
   always_comb begin
      w_issue = 1'b0;
      case (r_state)
         ST_IDLE: w_issue = cfg_start && !pkt_tx_full;
         ST_SEND: w_issue = !pkt_tx_full && (!r_post_eop || (!w_end && (r_ipg == 8'd0)));
         ST_GAP:  w_issue = !pkt_tx_full && !w_stop && (r_gap == 8'd0);
         default: w_issue = 1'b0;
      endcase
   end

   // Beat payload, first byte in the top lane, bytes past the frame end zeroed
   always_comb begin
      w_beat = '0;
      for (int j = 0; j < B; j++) begin
         logic [LEN_W:0] v_pos;
         logic [7:0]     v_byte;
         v_pos  = {1'b0, w_byte_cur} + (LEN_W+1)'(j);
         if (w_mode == PAT_LFSR)
            v_byte = w_lfsr_cur[31-8*(j%4) -: 8];
         else
            v_byte = w_byte_cur[7:0] + 8'(j);
         if (v_pos >= {1'b0, w_len})
            v_byte = 8'd0;
         w_beat[DATA_W-1-8*j -: 8] = v_byte;
      end
   end

   xge_lfsr32 u_lfsr (
      .clk     (clk_156m25),
      .reset   (reset_156m25),
      .i_en    (w_issue),
      .i_load  (w_load),
      .o_state (w_lfsr_q)
   );

   // Run FSM; frame-end decisions are taken on the edge after the eop beat
   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_count    <= '0;
         r_ipg      <= '0;
         r_mode     <= PAT_INC;
         r_stop     <= 1'b0;
         r_byte_cnt <= '0;
         r_post_eop <= 1'b0;
         r_gap      <= '0;
         r_data     <= '0;
         r_val      <= 1'b0;
         r_sop      <= 1'b0;
         r_eop      <= 1'b0;
         r_mod      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sent     <= '0;
      end else begin
         r_data <= '0;
         r_val  <= 1'b0;
         r_sop  <= 1'b0;
         r_eop  <= 1'b0;
         r_mod  <= '0;
         r_done <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (cfg_start) begin
                  r_len      <= w_cfg_len_cl;
                  r_count    <= cfg_count;
                  r_ipg      <= cfg_ipg;
                  r_mode     <= pat_mode_t'(cfg_mode);
                  r_stop     <= 1'b0;
                  r_sent     <= '0;
                  r_byte_cnt <= '0;
                  r_post_eop <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (cfg_stop)
                  r_stop <= 1'b1;
               if (r_post_eop) begin
                  r_post_eop <= 1'b0;
                  if (w_end) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (r_ipg != 8'd0) begin
                     r_state <= ST_GAP;
                     r_gap   <= r_ipg - 8'd1;
                  end
               end
            end
            ST_GAP: begin
               if (w_stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (r_gap == 8'd0) begin
                  r_state <= ST_SEND;
               end else begin
                  r_gap <= r_gap - 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         if (w_issue) begin
            r_val      <= 1'b1;
            r_data     <= w_beat;
            r_sop      <= (w_byte_cur == '0);
            r_eop      <= w_last;
            r_mod      <= w_last ? w_len[MOD_W-1:0] : '0;
            r_byte_cnt <= w_last ? '0 : (w_byte_cur + LEN_W'(B));
            r_post_eop <= w_last;
            if (w_last)
               r_sent <= w_sent_base + CNT_W'(1);
         end
      end
   end

   assign pkt_tx_data  = r_data;
   assign pkt_tx_val   = r_val;
   assign pkt_tx_sop   = r_sop;
   assign pkt_tx_eop   = r_eop;
   assign pkt_tx_mod   = r_mod;
   assign busy         = r_busy;
   assign done         = r_done;
   assign pkt_sent_cnt = r_sent;

endmodule

// File: tb/tb_xge_pkt_gen.sv
// tb/tb_xge_pkt_gen.sv - Directed self-checking bench for xge_pkt_gen
module tb_xge_pkt_gen;

   logic        clk_156m25 = 1'b0;
   logic        reset_156m25;
   logic        cfg_start;
   logic        cfg_stop;
   logic [13:0] cfg_len;
   logic [31:0] cfg_count;
   logic [7:0]  cfg_ipg;
   logic        cfg_mode;
   logic        pkt_tx_full;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        busy;
   logic        done;
   logic [31:0] pkt_sent_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] tb_lfsr;
   logic [63:0] first_beats [2];
   int          noval;
   int          gap;

   xge_pkt_gen dut (
      .clk_156m25   (clk_156m25),
      .reset_156m25 (reset_156m25),
      .cfg_start    (cfg_start),
      .cfg_stop     (cfg_stop),
      .cfg_len      (cfg_len),
      .cfg_count    (cfg_count),
      .cfg_ipg      (cfg_ipg),
      .cfg_mode     (cfg_mode),
      .pkt_tx_full  (pkt_tx_full),
      .pkt_tx_data  (pkt_tx_data),
      .pkt_tx_val   (pkt_tx_val),
      .pkt_tx_sop   (pkt_tx_sop),
      .pkt_tx_eop   (pkt_tx_eop),
      .pkt_tx_mod   (pkt_tx_mod),
      .busy         (busy),
      .done         (done),
      .pkt_sent_cnt (pkt_sent_cnt)
   );

   always #5 clk_156m25 = ~clk_156m25;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_156m25);
      #1;
   endtask

   task automatic start_run(input int len, input int count, input int ipg, input bit mode);
      cfg_len   = 14'(len);
      cfg_count = 32'(count);
      cfg_ipg   = 8'(ipg);
      cfg_mode  = mode;
      cfg_start = 1'b1;
      tb_lfsr   = 32'hFFFF_FFFF;
      step();
      cfg_start = 1'b0;
   endtask

   // Walks one frame from the current sample; len is the post-clamp length
   task automatic collect(input int len, input bit mode, input int stall_after,
                          input int stall_cycles, input int stop_at, output int nv);
      int  n = 0;
      int  nb = (len + 7) / 8;
      int  stall_left = 0;
      bit  got_eop = 0;
      bit  stop_clr = 0;
      logic [63:0] exp;
      nv = 0;
      for (int c = 0; c < 200 && !got_eop; c++) begin
         if (pkt_tx_val) begin
            exp = '0;
            for (int j = 0; j < 8; j++) begin
               int pos = n * 8 + j;
               logic [7:0] bv = 8'd0;
               if (pos < len)
                  bv = mode ? 8'(tb_lfsr >> (8 * (3 - (j % 4)))) : 8'(pos);
               exp = (exp << 8) | {56'd0, bv};
            end
            if (n < 2) first_beats[n] = pkt_tx_data;
            chk($sformatf("data[%0d]", n), pkt_tx_data, exp);
            chk($sformatf("sop[%0d]", n), pkt_tx_sop, (n == 0));
            chk($sformatf("eop[%0d]", n), pkt_tx_eop, (n == nb - 1));
            chk($sformatf("mod[%0d]", n), pkt_tx_mod, (n == nb - 1) ? 64'(len % 8) : 64'd0);
            tb_lfsr = {1'b0, tb_lfsr[31:1]} ^ (tb_lfsr[0] ? 32'h8020_0003 : 32'h0);
            if (pkt_tx_eop) got_eop = 1;
            n++;
            if (n == stall_after) begin
               pkt_tx_full = 1'b1;
               stall_left  = stall_cycles;
            end
            if (n == stop_at) begin
               cfg_stop = 1'b1;
               stop_clr = 1;
            end
         end else if (n > 0) begin
            nv++;
         end
         if (!got_eop) begin
            step();
            if (stop_clr) begin
               cfg_stop = 1'b0;
               stop_clr = 0;
            end
            if (stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) pkt_tx_full = 1'b0;
            end
         end
      end
      chk("eop_seen", 64'(got_eop), 64'd1);
      chk("beat_count", 64'(n), 64'(nb));
   endtask

   task automatic count_gap(output int g);
      g = 0;
      step();
      while (!pkt_tx_val && g < 50) begin
         g++;
         step();
      end
   endtask

   initial begin
      reset_156m25 = 1'b1;
      cfg_start    = 1'b0;
      cfg_stop     = 1'b0;
      cfg_len      = '0;
      cfg_count    = '0;
      cfg_ipg      = '0;
      cfg_mode     = 1'b0;
      pkt_tx_full  = 1'b0;
      tb_lfsr      = 32'hFFFF_FFFF;
      repeat (3) step();
      chk("rst_val", pkt_tx_val, 0);
      chk("rst_data", pkt_tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", pkt_sent_cnt, 0);
      reset_156m25 = 1'b0;
      step();

      // len 64, one frame, incrementing bytes
      start_run(64, 1, 0, 0);
      chk("t1_busy", busy, 1);
      collect(64, 0, -1, 0, -1, noval);
      chk("t1_beat0", first_beats[0], 64'h0001020304050607);
      chk("t1_cnt", pkt_sent_cnt, 1);
      step();
      chk("t1_done", done, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_val_end", pkt_tx_val, 0);
      step();
      chk("t1_done_pulse", done, 0);

      // len 65 gives nine beats, last beat one byte
      start_run(65, 1, 0, 0);
      collect(65, 0, -1, 0, -1, noval);
      chk("t2_lastdata", pkt_tx_data, 64'h4000000000000000);
      chk("t2_mod", pkt_tx_mod, 1);
      step();
      chk("t2_done", done, 1);
      step();

      // short request clamped to 64
      start_run(10, 1, 0, 0);
      collect(64, 0, -1, 0, -1, noval);
      step();
      chk("t3_done", done, 1);
      step();

      // three frames with a four-cycle gap
      start_run(64, 3, 4, 0);
      collect(64, 0, -1, 0, -1, noval);
      count_gap(gap);
      chk("t4_gap1", gap, 4);
      collect(64, 0, -1, 0, -1, noval);
      count_gap(gap);
      chk("t4_gap2", gap, 4);
      collect(64, 0, -1, 0, -1, noval);
      step();
      chk("t4_done", done, 1);
      chk("t4_cnt", pkt_sent_cnt, 3);
      chk("t4_busy", busy, 0);
      step();

      // five-cycle backpressure after the third beat
      start_run(64, 1, 0, 0);
      collect(64, 0, 3, 5, -1, noval);
      chk("t5_stall_noval", noval, 5);
      step();
      chk("t5_done", done, 1);
      step();

      // unbounded LFSR run stopped during frame two
      start_run(64, 0, 2, 1);
      collect(64, 1, -1, 0, -1, noval);
      chk("t6_lfsr_b0", first_beats[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_lfsr_b1", first_beats[1], 64'hFFDF_FFFC_FFDF_FFFC);
      count_gap(gap);
      chk("t6_gap", gap, 2);
      collect(64, 1, -1, 0, 3, noval);
      chk("t6_cnt_eop", pkt_sent_cnt, 2);
      step();
      chk("t6_done", done, 1);
      chk("t6_busy", busy, 0);
      chk("t6_cnt", pkt_sent_cnt, 2);
      step();
      chk("t6_idle_val", pkt_tx_val, 0);

      // reset in the middle of a frame, then a clean frame
      start_run(64, 1, 0, 0);
      step();
      step();
      chk("t7_midframe_val", pkt_tx_val, 1);
      reset_156m25 = 1'b1;
      step();
      reset_156m25 = 1'b0;
      chk("t7_rst_val", pkt_tx_val, 0);
      chk("t7_rst_data", pkt_tx_data, 0);
      chk("t7_rst_sop", pkt_tx_sop, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_cnt", pkt_sent_cnt, 0);
      step();
      chk("t7_idle_val", pkt_tx_val, 0);
      start_run(64, 1, 0, 0);
      collect(64, 0, -1, 0, -1, noval);
      step();
      chk("t7_done", done, 1);
      chk("t7_cnt", pkt_sent_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
